// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory channel between NUM_PORTS
// requesters; an in-order ID FIFO steers each response back to its issuing port.
module mem_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int OUTSTANDING    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  port_req_i,
  input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0]   port_add_i,
  input  logic [NUM_PORTS-1:0]                  port_wen_i,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]   port_wdata_i,
  input  logic [NUM_PORTS*AXI_STRB_WIDTH-1:0]   port_be_i,
  output logic [NUM_PORTS-1:0]                  port_gnt_o,
  output logic [NUM_PORTS-1:0]                  port_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]             port_r_rdata_o,
  output logic                                  mem_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]             mem_add_o,
  output logic                                  mem_wen_o,
  output logic [AXI_DATA_WIDTH-1:0]             mem_wdata_o,
  output logic [AXI_STRB_WIDTH-1:0]             mem_be_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]             mem_r_rdata_i,
  output logic                                  err_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [AXI_ADDR_WIDTH-1:0] add_arr   [NUM_PORTS];
  logic [AXI_DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [AXI_STRB_WIDTH-1:0] be_arr    [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign add_arr[gi]   = port_add_i[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign wdata_arr[gi] = port_wdata_i[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      assign be_arr[gi]    = port_be_i[gi*AXI_STRB_WIDTH +: AXI_STRB_WIDTH];
    end
  endgenerate

  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg;
  logic [IDX_W-1:0] fifo_mem [OUTSTANDING];

  logic [IDX_W-1:0] sel;
  logic [IDX_W:0]   cand;
  logic             found;
  logic             fifo_full, fifo_empty;
  logic             grant, pop, spurious;
  logic [IDX_W-1:0] fifo_head;

  // Search from rr_ptr upward, wrapping at NUM_PORTS (which need not be a power of 2).
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS))
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!found && port_req_i[cand[IDX_W-1:0]]) begin
        sel   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign fifo_full  = (count_reg == CNT_W'(OUTSTANDING));
  assign fifo_empty = (count_reg == '0);
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  // Gate with rst so nothing leaks to memory while reset is held.
  assign mem_req_o = (|port_req_i) & ~fifo_full & ~rst;
  assign grant     = mem_req_o & mem_gnt_i;
  assign pop       = mem_r_valid_i & ~fifo_empty;
  assign spurious  = mem_r_valid_i & fifo_empty;

  always_comb begin
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (mem_req_o) begin
      mem_add_o   = add_arr[sel];
      mem_wen_o   = port_wen_i[sel];
      mem_wdata_o = wdata_arr[sel];
      mem_be_o    = be_arr[sel];
    end
  end

  always_comb begin
    port_gnt_o     = '0;
    port_r_valid_o = '0;
    if (grant)
      port_gnt_o[sel] = 1'b1;
    if (pop)
      port_r_valid_o[fifo_head] = 1'b1;
  end

  assign port_r_rdata_o = mem_r_rdata_i;
  assign err_o          = err_reg;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant)
      rr_ptr_next = (sel == IDX_W'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
    count_next = count_reg;
    if (grant && !pop)
      count_next = count_reg + 1'b1;
    else if (!grant && pop)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      count_reg  <= count_next;
      if (grant)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (spurious)
        err_reg <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (grant)
      fifo_mem[wr_ptr_reg] <= sel;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, fairness, full backpressure,
// push/pop ordering, spurious response and mid-burst reset.
module tb_mem_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int OS = 4;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    req, wen;
  logic [NP*AW-1:0] add;
  logic [NP*DW-1:0] wdata;
  logic [NP*SW-1:0] be;
  logic [NP-1:0]    gnt, r_valid;
  logic [DW-1:0]    r_rdata;
  logic             mem_req, mem_wen;
  logic [AW-1:0]    mem_add;
  logic [DW-1:0]    mem_wdata;
  logic [SW-1:0]    mem_be;
  logic             mem_gnt, mem_rv;
  logic [DW-1:0]    mem_rdata;
  logic             err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .NUM_PORTS(NP), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_STRB_WIDTH(SW), .OUTSTANDING(OS)
  ) dut (
    .clk(clk), .rst(rst),
    .port_req_i(req), .port_add_i(add), .port_wen_i(wen),
    .port_wdata_i(wdata), .port_be_i(be),
    .port_gnt_o(gnt), .port_r_valid_o(r_valid), .port_r_rdata_o(r_rdata),
    .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_wen_o(mem_wen),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_r_valid_i(mem_rv), .mem_r_rdata_i(mem_rdata),
    .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      $display("ok   %-16s obs=%0h", tag, obs);
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0]  fair_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]  fair_rv  [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
  logic [31:0] fair_add [4] = '{32'h100, 32'h200, 32'h100, 32'h200};

  initial begin
    rst       = 1'b1;
    req       = 2'b11;
    wen       = 2'b10;
    add       = {32'h0000_0200, 32'h0000_0100};
    wdata     = {32'hBBBB_0001, 32'hAAAA_0000};
    be        = {4'h3, 4'hF};
    mem_gnt   = 1'b1;
    mem_rv    = 1'b0;
    mem_rdata = 32'h0;
    #2;
    // Reset state while requests are present
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_mem_add", mem_add, 0);
    chk("rst_err", err, 0);
    chk("rst_rr_ptr", dut.rr_ptr_reg, 0);
    tick();
    rst = 1'b0;

    // Single port read, latency 1
    req = 2'b01;
    add = {32'h0000_0200, 32'h0000_0010};
    #1;
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_mem_add", mem_add, 32'h10);
    chk("t1_mem_be", mem_be, 4'hF);
    chk("t1_mem_wen", mem_wen, 0);
    chk("t1_mem_wdata", mem_wdata, 32'hAAAA_0000);
    tick();
    req       = 2'b00;
    mem_rv    = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("t1_rvalid", r_valid, 2'b01);
    chk("t1_rdata", r_rdata, 32'hCAFE_F00D);
    chk("t1_mem_req_idle", mem_req, 0);
    tick();
    mem_rv = 1'b0;
    chk("t1_count", dut.count_reg, 0);
    chk("t1_rr_ptr", dut.rr_ptr_reg, 1);

    // Fairness: both ports request, memory latency 1
    pulse_reset();
    add = {32'h0000_0200, 32'h0000_0100};
    req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      mem_rv    = (c > 0);
      mem_rdata = 32'hD0 + 32'(c);
      #1;
      chk($sformatf("fair_gnt%0d", c), gnt, fair_gnt[c]);
      chk($sformatf("fair_rv%0d", c), r_valid, fair_rv[c]);
      chk($sformatf("fair_add%0d", c), mem_add, fair_add[c]);
      tick();
    end
    req    = 2'b00;
    mem_rv = 1'b1;
    #1;
    chk("fair_rv_last", r_valid, 2'b10);
    chk("fair_wen_idle", mem_wen, 0);
    tick();
    mem_rv = 1'b0;
    chk("fair_count", dut.count_reg, 0);

    // Backpressure: memory withholds responses
    pulse_reset();
    req = 2'b01;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_gnt%0d", c), gnt, 2'b01);
      tick();
    end
    #1;
    chk("bp_full_req", mem_req, 0);
    chk("bp_full_gnt", gnt, 2'b00);
    chk("bp_full_count", dut.count_reg, 4);
    tick();
    mem_rv = 1'b1;
    #1;
    chk("bp_pop_rvalid", r_valid, 2'b01);
    chk("bp_pop_req", mem_req, 0);
    chk("bp_pop_gnt", gnt, 2'b00);
    tick();
    mem_rv = 1'b0;
    #1;
    chk("bp_5th_req", mem_req, 1);
    chk("bp_5th_gnt", gnt, 2'b01);
    tick();
    chk("bp_refull_count", dut.count_reg, 4);
    req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      mem_rv = 1'b1;
      #1;
      chk($sformatf("bp_drain%0d", c), r_valid, 2'b01);
      tick();
    end
    mem_rv = 1'b0;
    chk("bp_drain_count", dut.count_reg, 0);

    // Simultaneous push/pop at count 2 with mixed port order
    pulse_reset();
    req = 2'b10;
    #1;
    chk("pp_gnt_a", gnt, 2'b10);
    tick();
    req = 2'b01;
    #1;
    chk("pp_gnt_b", gnt, 2'b01);
    tick();
    chk("pp_count_2", dut.count_reg, 2);
    req    = 2'b01;
    mem_rv = 1'b1;
    #1;
    chk("pp_gnt_c", gnt, 2'b01);
    chk("pp_rv_c", r_valid, 2'b10);
    tick();
    chk("pp_count_c", dut.count_reg, 2);
    req = 2'b10;
    #1;
    chk("pp_gnt_d", gnt, 2'b10);
    chk("pp_rv_d", r_valid, 2'b01);
    tick();
    chk("pp_count_d", dut.count_reg, 2);
    req = 2'b00;
    #1;
    chk("pp_rv_e", r_valid, 2'b01);
    tick();
    chk("pp_rv_f", r_valid, 2'b10);
    tick();
    mem_rv = 1'b0;
    chk("pp_count_0", dut.count_reg, 0);

    // Spurious response with empty FIFO
    chk("sp_err_before", err, 0);
    mem_rv = 1'b1;
    #1;
    chk("sp_rvalid", r_valid, 2'b00);
    tick();
    mem_rv = 1'b0;
    #1;
    chk("sp_err_set", err, 1);
    chk("sp_count", dut.count_reg, 0);
    tick();
    tick();
    chk("sp_err_held", err, 1);

    // Reset mid-burst with 3 outstanding
    req = 2'b01;
    for (int c = 0; c < 3; c++) tick();
    chk("mb_count_3", dut.count_reg, 3);
    req    = 2'b11;
    mem_rv = 1'b1;
    rst    = 1'b1;
    #1;
    chk("mb_mem_req", mem_req, 0);
    chk("mb_gnt", gnt, 2'b00);
    chk("mb_rvalid", r_valid, 2'b00);
    chk("mb_err", err, 0);
    chk("mb_rr_ptr", dut.rr_ptr_reg, 0);
    chk("mb_count", dut.count_reg, 0);
    chk("mb_mem_add", mem_add, 0);
    tick();
    rst    = 1'b0;
    mem_rv = 1'b0;
    #1;
    chk("mb_first_gnt", gnt, 2'b01);
    mem_gnt = 1'b0;
    #1;
    chk("mb_hold_req", mem_req, 1);
    chk("mb_hold_add", mem_add, 32'h100);
    chk("mb_hold_gnt", gnt, 2'b00);
    tick();
    req    = 2'b00;
    mem_rv = 1'b1;
    #1;
    chk("mb_late_rvalid", r_valid, 2'b00);
    tick();
    mem_rv = 1'b0;
    chk("mb_late_err", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
